// File: rtl/sum_accumulator.sv
// Accumulates C_ACC_NUM unsigned adder sums into one result, offered on a
// valid/ready port and held until the sink takes it.
module sum_accumulator #(
  parameter int C_DATA_WIDTH = 4,
  parameter int C_ACC_NUM    = 8
) (
  input  logic                                           I_sys_clk,
  input  logic                                           I_rst_n,
  input  logic                                           I_clear,
  input  logic                                           I_sum_valid,
  input  logic [C_DATA_WIDTH:0]                          I_sum,
  output logic                                           O_sum_ready,
  output logic                                           O_acc_valid,
  output logic [C_DATA_WIDTH+1+$clog2(C_ACC_NUM)-1:0]    O_acc_data,
  input  logic                                           I_acc_ready,
  output logic                                           O_busy
);
  localparam int C_ACC_WIDTH = C_DATA_WIDTH + 1 + $clog2(C_ACC_NUM);
  localparam int C_CNT_WIDTH = $clog2(C_ACC_NUM + 1);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] ACCUM = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  localparam logic [C_CNT_WIDTH-1:0] CNT_LAST = C_CNT_WIDTH'(C_ACC_NUM - 1);

  logic [1:0]             state;
  logic [C_ACC_WIDTH-1:0] acc;
  logic [C_CNT_WIDTH-1:0] cnt;
  logic [C_ACC_WIDTH-1:0] sum_ext;
  logic                   accept;

  assign O_sum_ready = (state != DONE) & ~I_clear;
  assign accept      = I_sum_valid & O_sum_ready;
  assign O_busy      = (state != IDLE);
  assign O_acc_valid = (state == DONE);
  assign O_acc_data  = acc;
  assign sum_ext     = C_ACC_WIDTH'(I_sum);

  // I_sum is only looked at on an accept, so junk on idle cycles never lands in acc
  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else if (I_clear) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc   <= sum_ext;
          cnt   <= C_CNT_WIDTH'(1);
          state <= (C_ACC_NUM == 1) ? DONE : ACCUM;
        end
        ACCUM: if (accept) begin
          acc <= acc + sum_ext;
          cnt <= cnt + C_CNT_WIDTH'(1);
          if (cnt == CNT_LAST) state <= DONE;
        end
        DONE: if (I_acc_ready) begin
          acc   <= '0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
